// File: rtl/iob_axis_word2byte_framer.sv
// ============================================================================
//  Module      : iob_axis_word2byte_framer
//  Description : Serialises a DATA_W-bit AXIS word stream into an 8-bit AXIS
//                byte stream. Each frame is exactly frame_len_i bytes long.
//                axis_out_last_o marks the final byte, and any unused trailing
//                byte lanes of the final word are discarded. Software starts
//                one frame at a time and watches busy_o and done_o.
//  Ports       : clk_i, cke_i, rst_n_i     clock, clock enable, sync active-low reset
//                frame_len_i, start_i      frame control (length sampled on start)
//                abort_i                   abandon the current frame, no done pulse
//                busy_o, done_o            status; done_o pulses for one cycle
//                byte_cnt_o                bytes still to send in the current frame
//                axis_in_*                 DATA_W word stream (byte 0 = bits [7:0])
//                axis_out_*                8-bit byte stream with last
//  Options     : IOB_AXIS_WORD2BYTE_PREFETCH_EN adds a one-word holding register
//                so the next word is fetched while the current one is shifted
//                out. This sustains 1 byte/cycle.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module iob_axis_word2byte_framer #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 12
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              rst_n_i,
    input  logic [LEN_W-1:0]  frame_len_i,
    input  logic              start_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              done_o,
    input  logic [DATA_W-1:0] axis_in_data_i,
    input  logic              axis_in_valid_i,
    output logic              axis_in_ready_o,
    output logic [7:0]        axis_out_data_o,
    output logic              axis_out_valid_o,
    input  logic              axis_out_ready_i,
    output logic              axis_out_last_o,
    output logic [LEN_W-1:0]  byte_cnt_o
);

    localparam int              c_nb        = DATA_W / 8;
    localparam int              c_lane_w    = (c_nb > 1) ? $clog2(c_nb) : 1;
    localparam logic [c_lane_w-1:0] c_last_lane = c_lane_w'(c_nb - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2
    } state_t;

    state_t              r_state,    w_state_nxt;
    logic [DATA_W-1:0]   r_shift,    w_shift_nxt;
    logic [c_lane_w-1:0] r_lane,     w_lane_nxt;
    logic [LEN_W-1:0]    r_byte_cnt, w_byte_cnt_nxt;
    logic                r_done,     w_done_nxt;

    logic w_in_ready;
    logic w_in_hs;
    logic w_out_hs;
    logic w_last_byte;
    logic w_last_lane;

`ifdef IOB_AXIS_WORD2BYTE_PREFETCH_EN
    localparam logic [31:0] c_nb_u = 32'(c_nb);

    logic [DATA_W-1:0] r_hold,      w_hold_nxt;
    logic              r_hold_full, w_hold_full_nxt;
    logic              w_need_word;

    // Another word is needed only if the frame has more bytes left than the
    // shift register still holds (lanes r_lane..NB-1). A word is never
    // prefetched unless the frame is going to use it.
    assign w_need_word = 32'(r_byte_cnt) > (c_nb_u - 32'(r_lane));
    assign w_in_ready  = (r_state == S_LOAD) ||
                         ((r_state == S_SHIFT) && !r_hold_full && w_need_word);
`else
    assign w_in_ready  = (r_state == S_LOAD);
`endif

    assign w_in_hs     = w_in_ready && axis_in_valid_i;
    assign w_out_hs    = (r_state == S_SHIFT) && axis_out_ready_i;
    assign w_last_byte = (r_byte_cnt == LEN_W'(1));
    assign w_last_lane = (r_lane == c_last_lane);

    // Every output is decoded from registered state only.
    assign busy_o           = (r_state != S_IDLE);
    assign done_o           = r_done;
    assign axis_in_ready_o  = w_in_ready;
    assign axis_out_valid_o = (r_state == S_SHIFT);
    assign axis_out_data_o  = r_shift[7:0];
    assign axis_out_last_o  = (r_state == S_SHIFT) && w_last_byte;
    assign byte_cnt_o       = r_byte_cnt;

    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_lane_nxt     = r_lane;
        w_byte_cnt_nxt = r_byte_cnt;
        w_done_nxt     = 1'b0;
`ifdef IOB_AXIS_WORD2BYTE_PREFETCH_EN
        w_hold_nxt      = r_hold;
        w_hold_full_nxt = r_hold_full;
`endif
        if (abort_i) begin
            // Abort wins over start and over a coincident byte handshake.
            w_state_nxt    = S_IDLE;
            w_lane_nxt     = '0;
            w_byte_cnt_nxt = '0;
`ifdef IOB_AXIS_WORD2BYTE_PREFETCH_EN
            w_hold_nxt      = '0;
            w_hold_full_nxt = 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        if (frame_len_i == '0) begin
                            w_done_nxt = 1'b1;
                        end else begin
                            w_byte_cnt_nxt = frame_len_i;
                            w_lane_nxt     = '0;
                            w_state_nxt    = S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_in_hs) begin
                        w_shift_nxt = axis_in_data_i;
                        w_lane_nxt  = '0;
                        w_state_nxt = S_SHIFT;
                    end
                end
                S_SHIFT: begin
`ifdef IOB_AXIS_WORD2BYTE_PREFETCH_EN
                    if (w_in_hs) begin
                        w_hold_nxt      = axis_in_data_i;
                        w_hold_full_nxt = 1'b1;
                    end
`endif
                    if (w_out_hs) begin
                        w_byte_cnt_nxt = r_byte_cnt - LEN_W'(1);
                        if (w_last_byte) begin
                            // Remaining lanes of this word are simply dropped.
                            w_state_nxt = S_IDLE;
                            w_lane_nxt  = '0;
                            w_done_nxt  = 1'b1;
                        end else if (w_last_lane) begin
                            w_lane_nxt = '0;
`ifdef IOB_AXIS_WORD2BYTE_PREFETCH_EN
                            if (r_hold_full) begin
                                w_shift_nxt     = r_hold;
                                w_hold_full_nxt = 1'b0;
                            end else if (w_in_hs) begin
                                // Word arrives on the same edge the last lane
                                // leaves: bypass the holding register.
                                w_shift_nxt     = axis_in_data_i;
                                w_hold_full_nxt = 1'b0;
                            end else begin
                                w_state_nxt = S_LOAD;
                            end
`else
                            w_state_nxt = S_LOAD;
`endif
                        end else begin
                            w_shift_nxt = r_shift >> 8;
                            w_lane_nxt  = r_lane + c_lane_w'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Clock enable gates every register, reset included.
    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            if (!rst_n_i) begin
                r_state    <= S_IDLE;
                r_shift    <= '0;
                r_lane     <= '0;
                r_byte_cnt <= '0;
                r_done     <= 1'b0;
`ifdef IOB_AXIS_WORD2BYTE_PREFETCH_EN
                r_hold      <= '0;
                r_hold_full <= 1'b0;
`endif
            end else begin
                r_state    <= w_state_nxt;
                r_shift    <= w_shift_nxt;
                r_lane     <= w_lane_nxt;
                r_byte_cnt <= w_byte_cnt_nxt;
                r_done     <= w_done_nxt;
`ifdef IOB_AXIS_WORD2BYTE_PREFETCH_EN
                r_hold      <= w_hold_nxt;
                r_hold_full <= w_hold_full_nxt;
`endif
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_iob_axis_word2byte_framer.sv
// ============================================================================
//  Module      : tb_iob_axis_word2byte_framer
//  Description : Directed self-checking bench for iob_axis_word2byte_framer
//                (DATA_W=32, LEN_W=12). Inputs are driven and outputs are
//                sampled on the falling clock edge.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_iob_axis_word2byte_framer;

    localparam int DATA_W = 32;
    localparam int LEN_W  = 12;
`ifdef IOB_AXIS_WORD2BYTE_PREFETCH_EN
    localparam int c_load_to_done = 9;
    localparam int c_span12       = 11;
`else
    localparam int c_load_to_done = 10;
    localparam int c_span12       = 13;
`endif

    logic              clk_i = 1'b0;
    logic              cke_i;
    logic              rst_n_i;
    logic [LEN_W-1:0]  frame_len_i;
    logic              start_i;
    logic              abort_i;
    logic              busy_o;
    logic              done_o;
    logic [DATA_W-1:0] axis_in_data_i;
    logic              axis_in_valid_i;
    logic              axis_in_ready_o;
    logic [7:0]        axis_out_data_o;
    logic              axis_out_valid_o;
    logic              axis_out_ready_i;
    logic              axis_out_last_o;
    logic [LEN_W-1:0]  byte_cnt_o;

    always #5 clk_i = ~clk_i;

    iob_axis_word2byte_framer #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) u_dut (
        .clk_i            (clk_i),
        .cke_i            (cke_i),
        .rst_n_i          (rst_n_i),
        .frame_len_i      (frame_len_i),
        .start_i          (start_i),
        .abort_i          (abort_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .axis_in_data_i   (axis_in_data_i),
        .axis_in_valid_i  (axis_in_valid_i),
        .axis_in_ready_o  (axis_in_ready_o),
        .axis_out_data_o  (axis_out_data_o),
        .axis_out_valid_o (axis_out_valid_o),
        .axis_out_ready_i (axis_out_ready_i),
        .axis_out_last_o  (axis_out_last_o),
        .byte_cnt_o       (byte_cnt_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [DATA_W-1:0] words[$];
    logic [7:0]        got[$];
    logic [7:0]        exp_q[$];
    int                cnt_trace[$];
    int n_words, n_last, last_idx, first_ld, first_vld, last_hs, done_cyc, stall_err;
    bit aborted;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic start_frame(input int len);
        @(negedge clk_i);
        start_i     = 1'b1;
        frame_len_i = LEN_W'(len);
        @(negedge clk_i);
        start_i     = 1'b0;
    endtask

    task automatic check_bytes(input string tag);
        chk({tag, "_nbytes"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
    endtask

    // Feeds the queued words, drives out-ready from a 4-cycle pattern and
    // records every byte handshake until done_o, an abort, or the budget.
    task automatic run_frame(input bit [3:0] rdy_pat, input int abort_after, input int budget);
        bit         fin;
        bit         prev_stalled;
        logic [7:0] prev_data;
        logic       prev_last;
        fin = 1'b0; prev_stalled = 1'b0; prev_data = '0; prev_last = 1'b0;
        got.delete(); cnt_trace.delete();
        n_words = 0; n_last = 0; last_idx = -1; first_ld = -1; first_vld = -1;
        last_hs = -1; done_cyc = -1; stall_err = 0; aborted = 1'b0;
        for (int c = 0; c < budget && !fin; c++) begin
            @(negedge clk_i);
            if (done_o) begin
                done_cyc = c;
                fin      = 1'b1;
            end else begin
                if (prev_stalled && (!axis_out_valid_o || axis_out_data_o !== prev_data ||
                                     axis_out_last_o !== prev_last))
                    stall_err++;
                axis_out_ready_i = rdy_pat[c % 4];
                axis_in_valid_i  = (words.size() > 0);
                axis_in_data_i   = (words.size() > 0) ? words[0] : '0;
                abort_i = (abort_after >= 0) && (got.size() == abort_after) &&
                          axis_out_valid_o && axis_out_ready_i;
                if (axis_out_valid_o && first_vld < 0) first_vld = c;
                if (abort_i) begin
                    aborted = 1'b1;
                    fin     = 1'b1;
                end else begin
                    if (axis_in_ready_o && axis_in_valid_i) begin
                        void'(words.pop_front());
                        n_words++;
                        if (first_ld < 0) first_ld = c;
                    end
                    if (axis_out_valid_o && axis_out_ready_i) begin
                        got.push_back(axis_out_data_o);
                        cnt_trace.push_back(int'(byte_cnt_o));
                        last_hs = c;
                        if (axis_out_last_o) begin
                            n_last++;
                            last_idx = got.size() - 1;
                        end
                    end
                    prev_stalled = axis_out_valid_o && !axis_out_ready_i;
                    prev_data    = axis_out_data_o;
                    prev_last    = axis_out_last_o;
                end
            end
        end
        if (!fin) chk("timeout", 32'd1, 32'd0);
        if (aborted) begin
            @(negedge clk_i);
            abort_i = 1'b0;
        end
        axis_in_valid_i  = 1'b0;
        axis_out_ready_i = 1'b0;
    endtask

    initial begin
        cke_i = 1'b1; rst_n_i = 1'b0; frame_len_i = '0; start_i = 1'b0; abort_i = 1'b0;
        axis_in_data_i = '0; axis_in_valid_i = 1'b0; axis_out_ready_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("rst_busy",  32'(busy_o), 0);
        chk("rst_done",  32'(done_o), 0);
        chk("rst_inrdy", 32'(axis_in_ready_o), 0);
        chk("rst_valid", 32'(axis_out_valid_o), 0);
        chk("rst_data",  32'(axis_out_data_o), 0);
        chk("rst_last",  32'(axis_out_last_o), 0);
        chk("rst_cnt",   32'(byte_cnt_o), 0);
        rst_n_i = 1'b1;

        // Clock enable low: start must be ignored.
        @(negedge clk_i);
        cke_i = 1'b0; start_i = 1'b1; frame_len_i = LEN_W'(3);
        @(negedge clk_i);
        chk("cke_hold_busy", 32'(busy_o), 0);
        chk("cke_hold_cnt",  32'(byte_cnt_o), 0);
        start_i = 1'b0; cke_i = 1'b1;

        // len 8, two full words, ready always high.
        words = '{32'h44332211, 32'h88776655};
        start_frame(8);
        run_frame(4'b1111, -1, 200);
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        check_bytes("f8");
        chk("f8_last_idx", 32'(last_idx), 32'd7);
        chk("f8_n_last",   32'(n_last), 32'd1);
        chk("f8_words",    32'(n_words), 32'd2);
        chk("f8_done_lat", 32'(done_cyc - last_hs), 32'd1);
        chk("f8_load2done", 32'(done_cyc - first_ld), 32'(c_load_to_done));
        @(negedge clk_i);
        chk("f8_done_pulse", 32'(done_o), 0);
        chk("f8_idle",       32'(busy_o), 0);

        // len 6: lanes 2-3 of the second word are dropped.
        words = '{32'hDDCCBBAA, 32'h0000FFEE};
        start_frame(6);
        run_frame(4'b1111, -1, 200);
        exp_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
        check_bytes("f6");
        chk("f6_last_idx", 32'(last_idx), 32'd5);
        chk("f6_words",    32'(n_words), 32'd2);
        chk("f6_idle",     32'(busy_o), 0);

        // len 5 with ready pattern 1,0,0,1: stalls must hold data/last.
        words = '{32'h04030201, 32'h00000005};
        start_frame(5);
        run_frame(4'b1001, -1, 200);
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        check_bytes("f5");
        chk("f5_stall_stable", 32'(stall_err), 0);
        chk("f5_last_idx", 32'(last_idx), 32'd4);
        for (int i = 0; i < cnt_trace.size(); i++)
            chk($sformatf("f5_cnt%0d", i), 32'(cnt_trace[i]), 32'(5 - i));
        chk("f5_cnt_end", 32'(byte_cnt_o), 0);

        // Abort on the 4th byte handshake of an 8-byte frame.
        words = '{32'h13121110, 32'h17161514};
        start_frame(8);
        run_frame(4'b1111, 3, 200);
        chk("ab_seen",  32'(aborted), 32'd1);
        chk("ab_busy",  32'(busy_o), 0);
        chk("ab_valid", 32'(axis_out_valid_o), 0);
        chk("ab_inrdy", 32'(axis_in_ready_o), 0);
        chk("ab_done",  32'(done_o), 0);
        @(negedge clk_i);
        chk("ab_done2", 32'(done_o), 0);
        words.delete();
        words = '{32'hA4A3A2A1};
        start_frame(4);
        run_frame(4'b1111, -1, 200);
        exp_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        check_bytes("ab_next");
        chk("ab_next_last", 32'(last_idx), 32'd3);

        // Zero-length frame: immediate done, nothing moves.
        start_frame(0);
        chk("z_done",  32'(done_o), 32'd1);
        chk("z_busy",  32'(busy_o), 0);
        chk("z_inrdy", 32'(axis_in_ready_o), 0);
        chk("z_valid", 32'(axis_out_valid_o), 0);
        @(negedge clk_i);
        chk("z_done_pulse", 32'(done_o), 0);

        // Start while busy is ignored.
        start_frame(4);
        chk("sb_busy", 32'(busy_o), 32'd1);
        start_frame(9);
        chk("sb_cnt", 32'(byte_cnt_o), 32'd4);
        words = '{32'h2D2C2B2A};
        run_frame(4'b1111, -1, 200);
        exp_q = '{8'h2A, 8'h2B, 8'h2C, 8'h2D};
        check_bytes("sb");
        chk("sb_words", 32'(n_words), 32'd1);

        // len 12, continuous valid/ready: span of valid cycles.
        words = '{32'h03020100, 32'h07060504, 32'h0B0A0908};
        start_frame(12);
        run_frame(4'b1111, -1, 200);
        exp_q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                  8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B};
        check_bytes("f12");
        chk("f12_words", 32'(n_words), 32'd3);
        chk("f12_span",  32'(last_hs - first_vld), 32'(c_span12));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/iob_axis_word2byte_framer.md
Name: iob_axis_word2byte_framer

Overview:
- Downstream stage of the AXI-read-to-AXIS converter: consumes its DATA_W-bit AXIS word stream and serialises it into an 8-bit AXIS byte stream for the Ethernet TX path.
- Generates axis_out_last_o after exactly frame_len_i bytes and discards unused trailing byte lanes of the final word.
- Software/DMA control starts one frame at a time; the block reports busy and done.

Parameters:
- DATA_W, 32, input word width; must be a multiple of 8 and at least 16; NB = DATA_W/8 byte lanes.
- LEN_W, 12, width of the frame byte count (maximum 2^LEN_W-1 bytes).

Ports:
- clk_i  input  1  clock
- cke_i  input  1  clock enable; when low, all registers hold
- rst_n_i  input  1  reset, synchronous, active-low
- frame_len_i  input  LEN_W  frame length in bytes; sampled on start
- start_i  input  1  start frame; honoured only in IDLE
- abort_i  input  1  abandon current frame
- busy_o  output  1  high when state != IDLE
- done_o  output  1  one-cycle pulse after the last byte handshake
- axis_in_data_i  input  DATA_W  word stream data, byte 0 = bits [7:0]
- axis_in_valid_i  input  1  word valid
- axis_in_ready_o  output  1  word ready
- axis_out_data_o  output  8  byte stream data
- axis_out_valid_o  output  1  byte valid
- axis_out_ready_i  input  1  byte ready
- axis_out_last_o  output  1  high with the final byte of the frame
- byte_cnt_o  output  LEN_W  bytes remaining in the current frame

Behaviour:
- Reset (rst_n_i=0 at a clk edge with cke_i=1): state IDLE. All outputs are 0 and all internal registers are 0.
- All outputs are driven from registers or decoded from registers only. There is no combinational path from axis_out_ready_i or axis_in_valid_i to any output.
- IDLE:
  - busy_o=0, axis_in_ready_o=0, axis_out_valid_o=0.
  - start_i with frame_len_i>0: latch byte_cnt=frame_len_i, lane=0, go to LOAD.
  - start_i with frame_len_i=0: stay in IDLE, pulse done_o next cycle, consume no words.
- LOAD:
  - axis_in_ready_o=1.
  - On in-handshake: capture word into shift register, lane=0, go to SHIFT.
- SHIFT:
  - axis_out_valid_o=1, axis_out_data_o=shift[7:0], axis_out_last_o=(byte_cnt==1).
  - On out-handshake: byte_cnt decrements.
  - If byte_cnt was 1: go to IDLE and pulse done_o in the following cycle. Unused lanes of the last word are dropped.
  - Else, if lane==NB-1: go to LOAD.
  - Else: shift right by 8 and increment lane.
- AXIS rules:
  - While axis_out_valid_o=1 and ready=0, data and last are held stable.
  - Valid never depends on ready.
- Words consumed per frame = ceil(frame_len/NB). No extra words are taken.
- Throughput without the optional feature: NB bytes per NB+1 cycles. First byte is valid 1 cycle after the LOAD in-handshake.
- abort_i:
  - Has highest priority in any state, including over start_i in IDLE and over a simultaneous out-handshake.
  - Next state is IDLE, with valid/ready deasserted next cycle and no done_o pulse.
  - A byte not yet accepted is dropped; this is the only permitted valid withdrawal.
- start_i while busy: ignored.
- cke_i=0: no state change and outputs frozen, including during reset.

Optional Feature:
- Macro IOB_AXIS_WORD2BYTE_PREFETCH_EN.
- With the macro defined:
  - Adds one DATA_W holding register. axis_in_ready_o is high in SHIFT whenever the holding register is empty and at least one further word is still required for the frame.
  - When lane==NB-1 is handshaken and the holding register is full, the holding word moves to the shift register and the block stays in SHIFT.
  - Sustained throughput is 1 byte/cycle.
  - abort_i clears the holding register.
- Without the macro: no holding register; behaviour exactly as above.

Test Plan:
- DATA_W=32, frame_len=8, words 0x44332211, 0x88776655, out ready=1 -> bytes 11..88 in order, last only on 0x88, done_o 1 cycle after, exactly 2 in-handshakes, 10 cycles LOAD-to-done without prefetch.
- frame_len=6, words 0xDDCCBBAA, 0x0000FFEE -> bytes AA BB CC DD EE FF, last on FF, lanes 2-3 of word 2 dropped, block returns to IDLE.
- frame_len=5, out ready toggled 1-0-0-1 per cycle -> data/last stable while stalled, 5 bytes total, byte_cnt_o counts 5..0.
- Abort asserted after 3 of 8 bytes, same cycle as an out-handshake -> IDLE next cycle, no done_o, next start with len=4 outputs fresh bytes correctly.
- start with frame_len=0 -> no in-ready, no out-valid, done_o pulse 1 cycle later; start_i while busy -> ignored.
- With IOB_AXIS_WORD2BYTE_PREFETCH_EN, len=12, in valid and out ready continuously high -> 12 consecutive valid cycles, no bubbles, 3 words consumed.
